// File: rtl/fft_twiddle_sequencer.sv
// Twiddle-multiplier control sequencer for the 64-point radix-2 DIF FFT: walks 6 stages x 32 butterflies.
// Optional inter-stage drain gap is compiled in with `define FFTSEQ_STAGE_GAP_EN.
//
// state    | meaning
// S_IDLE   | waiting for start_i
// S_RUN    | presenting transfers, advancing on handshake
// S_GAP    | inter-stage idle cycles (FFTSEQ_STAGE_GAP_EN only)
// S_FINISH | one-cycle done pulse
module fft_twiddle_sequencer #(
  parameter int GAP_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       out_ready_i,
  output logic       out_valid_o,
  output logic [2:0] stage_o,
  output logic [4:0] bfly_o,
  output logic [4:0] tw_idx_o,
  output logic [3:0] coef_sel_o,
  output logic [2:0] typesel_o,
  output logic       trivial_o,
  output logic       busy_o,
  output logic       done_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
`ifdef FFTSEQ_STAGE_GAP_EN
    ,
    S_GAP    = 2'd3
`endif
  } state_t;

  if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_gap
    $error("GAP_CYCLES must be in 1..15");
  end

  state_t     state_q, state_d;
  logic [2:0] stage_q, stage_d;
  logic [4:0] bfly_q, bfly_d;
  logic [4:0] tw_idx_q, tw_idx_d;
  logic [3:0] coef_sel_q, coef_sel_d;
  logic [2:0] typesel_q, typesel_d;
  logic       trivial_q, trivial_d;
  logic       out_valid_q, out_valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

`ifdef FFTSEQ_STAGE_GAP_EN
  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);
  logic [3:0] gap_cnt_q, gap_cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    bfly_d  = bfly_q;
`ifdef FFTSEQ_STAGE_GAP_EN
    gap_cnt_d = gap_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          stage_d = '0;
          bfly_d  = '0;
        end
      end
      S_RUN: begin
        if (out_valid_q && out_ready_i) begin
          if (bfly_q == 5'd31) begin
            bfly_d = '0;
            if (stage_q == 3'd5) begin
              state_d = S_FINISH;
            end else begin
              stage_d = stage_q + 3'd1;
`ifdef FFTSEQ_STAGE_GAP_EN
              state_d   = S_GAP;
              gap_cnt_d = GAP_LOAD;
`endif
            end
          end else begin
            bfly_d = bfly_q + 5'd1;
          end
        end
      end
`ifdef FFTSEQ_STAGE_GAP_EN
      S_GAP: begin
        if (gap_cnt_q == 4'd0) begin
          state_d = S_RUN;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
`endif
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // k = (bfly mod (32>>stage)) << stage equals bfly << stage truncated to 5 bits.
  always_comb begin
    tw_idx_d    = bfly_d << stage_d;
    coef_sel_d  = tw_idx_d[3] ? (4'd8 - {1'b0, tw_idx_d[2:0]}) : {1'b0, tw_idx_d[2:0]};
    typesel_d   = {tw_idx_d[3], tw_idx_d[4], tw_idx_d[4] ^ tw_idx_d[3]};
    trivial_d   = (coef_sel_d == 4'd0);
    out_valid_d = (state_d == S_RUN);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_FINISH);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      stage_q     <= '0;
      bfly_q      <= '0;
      tw_idx_q    <= '0;
      coef_sel_q  <= '0;
      typesel_q   <= '0;
      trivial_q   <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      bfly_q      <= bfly_d;
      tw_idx_q    <= tw_idx_d;
      coef_sel_q  <= coef_sel_d;
      typesel_q   <= typesel_d;
      trivial_q   <= trivial_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef FFTSEQ_STAGE_GAP_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gap_cnt_q <= '0;
    end else begin
      gap_cnt_q <= gap_cnt_d;
    end
  end
`endif

  assign out_valid_o = out_valid_q;
  assign stage_o     = stage_q;
  assign bfly_o      = bfly_q;
  assign tw_idx_o    = tw_idx_q;
  assign coef_sel_o  = coef_sel_q;
  assign typesel_o   = typesel_q;
  assign trivial_o   = trivial_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
// Directed bench for fft_twiddle_sequencer: full runs, mapping vectors, stalls, reset abort.
// Expects the inter-stage gap when compiled with FFTSEQ_STAGE_GAP_EN.
module tb_fft_twiddle_sequencer;

`ifdef FFTSEQ_STAGE_GAP_EN
  localparam int G = 4;
`else
  localparam int G = 0;
`endif

  logic       clk = 1'b0;
  logic       rst, start, ready;
  logic       valid, triv, busy, done;
  logic [2:0] stage, ts;
  logic [4:0] bfly, tw;
  logic [3:0] coef;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fft_twiddle_sequencer #(.GAP_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .out_ready_i(ready),
    .out_valid_o(valid), .stage_o(stage), .bfly_o(bfly), .tw_idx_o(tw),
    .coef_sel_o(coef), .typesel_o(ts), .trivial_o(triv),
    .busy_o(busy), .done_o(done)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [20:0] cur_word();
    return {stage, bfly, tw, coef, ts, triv};
  endfunction

  // Expected {stage,bfly,tw,coef,typesel,trivial} for the t-th transfer.
  function automatic logic [20:0] exp_word(input int t);
    int s, b, k;
    logic [4:0] kk;
    logic [3:0] c;
    logic [2:0] y;
    s  = t / 32;
    b  = t % 32;
    k  = (b % (32 >> s)) << s;
    kk = k[4:0];
    c  = kk[3] ? (4'd8 - {1'b0, kk[2:0]}) : {1'b0, kk[2:0]};
    y  = {kk[3], kk[4], kk[4] ^ kk[3]};
    return {s[2:0], b[4:0], kk, c, y, (c == 4'd0)};
  endfunction

  task automatic hand_checks(input int idx);
    case (idx)
      0:  check_eq("first_xfer", {stage, bfly, tw, triv}, {3'd0, 5'd0, 5'd0, 1'b1});
      5:  check_eq("s0_b5",  {tw, coef, ts}, {5'd5, 4'd5, 3'b000});
      11: check_eq("s0_b11", {coef, ts}, {4'd5, 3'b101});
      16: check_eq("s0_b16", {coef, ts, triv}, {4'd0, 3'b011, 1'b1});
      24: check_eq("s0_b24", {coef, ts}, {4'd8, 3'b110});
      77: check_eq("s2_b13", {tw, coef, ts}, {5'd20, 4'd4, 3'b011});
      default: if (idx >= 160) check_eq("s5_tw0", tw, 5'd0);
    endcase
  endtask

  task automatic run_xfers(input int stall_pct, input int mid_start_cyc, input int rst_at);
    int idx = 0, cyc = 0, done_cyc = -1, last_hs = -1, gap_run = 0, gap_total = 0;
    logic hold = 1'b0;
    logic [21:0] held = '0, word;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    check_eq("busy_after_start", {busy, valid}, 2'b11);
    while (cyc < 1000) begin
      if (rst_at >= 0 && idx == rst_at) begin
        start = 1'b0;
        rst   = 1'b1;
        step();
        rst   = 1'b0;
        check_eq("reset_mid_run", {valid, busy, done, cur_word()}, {3'b000, 21'h1});
        return;
      end
      ready = ($urandom_range(99) >= stall_pct);
      start = (cyc == mid_start_cyc);
      word  = {valid, cur_word()};
      if (hold) check_eq("stall_hold", word, held);
      if (valid) begin
        if (gap_run > 0) begin
          check_eq("gap_len", gap_run, G);
          gap_run = 0;
        end
        if (ready) begin
          check_eq("xfer", cur_word(), exp_word(idx));
          hand_checks(idx);
          idx++;
          last_hs = cyc;
        end
      end else if (busy && !done) begin
        gap_run++;
        gap_total++;
      end
      hold = valid && !ready;
      held = word;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      step();
      cyc++;
    end
    check_eq("done_seen", (done_cyc >= 0), 1'b1);
    check_eq("xfer_count", idx, 192);
    check_eq("done_after_last", done_cyc, last_hs + 1);
    check_eq("gap_total", gap_total, 5 * G);
    if (stall_pct == 0) check_eq("done_cycle", done_cyc, 193 + 5 * G);
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("idle_after_done", {busy, valid, done}, 3'b000);
    step();
    check_eq("start_in_done_ignored", {busy, valid}, 2'b00);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    ready = 1'b0;
    repeat (3) step();
    check_eq("reset_values", {valid, busy, done, cur_word()}, {3'b000, 21'h1});
    rst = 1'b0;
    step();
    check_eq("idle_hold", {valid, busy, done, cur_word()}, {3'b000, 21'h1});

    run_xfers(0, -1, -1);
    run_xfers(35, -1, -1);
    run_xfers(20, 3, 100);
    step();
    run_xfers(0, -1, -1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
